dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the shared 16-bit data memory. Lets the CPU load/store unit (port 0) and the program/debug loader (port 1) access one single-ported data memory instance without conflicts. Each accepted request is registered, issued as exactly one memory cycle, and completed with a one-cycle acknowledge carrying registered read data. Sits between the requesters and the memory's address, data_write, mem_write, mem_read and data_read pins.

## Interface
- ADDR_W, 16: byte address width; the memory uses address bits [ADDR_W-1:1] as the word index.
- DATA_W, 16: data word width.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- p0_req / p1_req  in  1  request; held high until the matching ack.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  ADDR_W  byte address.
- p0_wdata / p1_wdata  in  DATA_W  write data.
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- p0_rdata / p1_rdata  out  DATA_W  both driven from the same rdata_q register; a port's value is valid only while its own ack is high.
- mem_address  out  ADDR_W  to memory address.
- mem_data_write  out  DATA_W  to memory data_write.
- mem_write  out  1  to memory mem_write.
- mem_read  out  1  to memory mem_read.
- mem_data_read  in  DATA_W  from memory data_read; combinational, zero when mem_read is low.
- busy  out  1  high in ACCESS or RESP.
- gnt_id  out  1  port index of the current or last transaction.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is high, pick a winner and latch its we, addr and wdata into addr_q, we_q and wdata_q.
  - Set gnt_id to the winner and go to ACCESS.
  - Otherwise stay in IDLE.
- Winner selection is round-robin over last_gnt:
  - Only one port requesting: that port wins.
  - Both requesting: the port not equal to last_gnt wins.
  - last_gnt updates on entry to ACCESS.
- ACCESS (exactly one cycle):
  - mem_address = addr_q, mem_data_write = wdata_q.
  - mem_write = we_q, mem_read = !we_q.
  - The write commits at the closing edge. For a read, rdata_q captures mem_data_read at the closing edge.
  - Always go to RESP.
- RESP (one cycle):
  - ack of port gnt_id is high; rdata_q is held.
  - Requests are ignored in this cycle, because the requester may still be presenting the old transaction.
  - Always go to IDLE.
- mem_write and mem_read are zero outside ACCESS and are decoded from the state register only.
- A write leaves rdata_q unchanged.
- Address bit 0 is passed through unchanged; the memory ignores it.
- A request dropped or changed after being latched is ignored; the latched transaction completes and is acked.
- Port requests are not queued. A losing port simply keeps req high.

## Timing
- Reset values (asynchronous, while rst_n is low):
  - state = IDLE.
  - last_gnt = 1, so port 0 wins the first tie.
  - gnt_id = 0.
  - addr_q, wdata_q, we_q and rdata_q = 0.
  - All outputs are 0.
- Latency: req high in IDLE cycle N, then ACCESS in N+1, then ack high in N+2.
- The earliest next grant is decided in the IDLE cycle N+3. Peak throughput is one transaction per 3 cycles.
- Under continuous requests from both ports, service alternates 0,1,0,1… so neither port waits more than one transaction.
- Reset asserted during ACCESS:
  - mem_write drops immediately, so no write occurs at the next edge.
  - ack is lost; the requester must reissue after reset.
- Reset released: the first grant is possible in the first IDLE cycle with a synchronous request present.
- Both acks are never high in the same cycle. At most one memory access per 3 cycles.

## Structure
- Shared package dmem_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the port-index type;
  - the ADDR_W and DATA_W defaults shared with the data memory.
- Sub-module rr_arb2 is a combinational 2-way round-robin picker: inputs req[1:0] and last_gnt; outputs valid and winner.
- Everything else (FSM and latching registers) lives in dmem_arbiter.

## Test plan
- Port 1 writes 0xBEEF to address 0x0010; then port 0 reads 0x0010.
  - mem_write is high for one cycle with mem_address = 0x0010.
  - p1_ack is high 2 cycles after req.
  - The read acks with p0_rdata = 0xBEEF.
- Both ports request from reset (p0 read 0x0020, p1 read 0x0030, same cycle):
  - p0 is served first;
  - p1_ack comes 3 cycles after p0_ack;
  - gnt_id sequence is 0 then 1.
- Both ports hold req high for 6 transactions:
  - ack pattern alternates p0,p1,p0,p1,p0,p1;
  - no cycle has both acks high.
- Port 0 changes p0_addr from 0x0040 to 0x0050 during ACCESS:
  - the access uses 0x0040;
  - the ack still fires.
- Assert rst_n low during the ACCESS cycle of a write of 0x1234 to 0x0060:
  - mem_write goes low immediately;
  - a later read of 0x0060 returns 0x0000;
  - all outputs are 0 during reset.
- Port 0 reads 0x0070 (value 0x00AA), then writes 0x5555:
  - p0_rdata stays 0x00AA through the write's ack.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data memory and its arbiter.
package dmem_pkg;

  localparam int unsigned AddrW = 16;
  localparam int unsigned DataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  typedef logic port_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the port that did not win last time wins.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_gnt,
  output logic       valid,
  output port_t      winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_gnt;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared single-ported data memory: one registered
// request, one memory cycle, one ack cycle per transaction.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_write,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data_read,
  output logic              busy,
  output logic              gnt_id
);

  state_e              state_q, state_d;
  port_t               last_gnt_q, last_gnt_d;
  port_t               gnt_id_q, gnt_id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                arb_valid;
  port_t               arb_winner;

  rr_arb2 u_rr_arb2 (
    .req      ({p1_req, p0_req}),
    .last_gnt (last_gnt_q),
    .valid    (arb_valid),
    .winner   (arb_winner)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_id_d   = gnt_id_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d    = StAccess;
          gnt_id_d   = arb_winner;
          last_gnt_d = arb_winner;
          if (arb_winner) begin
            addr_d  = p1_addr;
            wdata_d = p1_wdata;
            we_d    = p1_we;
          end else begin
            addr_d  = p0_addr;
            wdata_d = p0_wdata;
            we_d    = p0_we;
          end
        end
      end
      StAccess: begin
        if (!we_q) rdata_d = mem_data_read;
        state_d = StResp;
      end
      // Requests are ignored here: the requester may still show the completed transaction.
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      gnt_id_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_id_q   <= gnt_id_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
    end
  end

  // Memory strobes decode from the state register only, so reset kills them immediately.
  always_comb begin
    mem_write      = (state_q == StAccess) && we_q;
    mem_read       = (state_q == StAccess) && !we_q;
    mem_address    = (state_q == StAccess) ? addr_q : '0;
    mem_data_write = (state_q == StAccess) ? wdata_q : '0;
    p0_ack         = (state_q == StResp) && (gnt_id_q == 1'b0);
    p1_ack         = (state_q == StResp) && (gnt_id_q == 1'b1);
    p0_rdata       = rdata_q;
    p1_rdata       = rdata_q;
    busy           = (state_q != StIdle);
    gnt_id         = gnt_id_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory, ack scoreboard, vector table and
// hand-written multi-cycle sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] mem_address, mem_data_write, mem_data_read;
  logic        mem_write, mem_read, busy, gnt_id;

  logic [15:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        port;
    logic [15:0] rdata;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_arbiter u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .p0_req         (p0_req),
    .p0_we          (p0_we),
    .p0_addr        (p0_addr),
    .p0_wdata       (p0_wdata),
    .p0_ack         (p0_ack),
    .p0_rdata       (p0_rdata),
    .p1_req         (p1_req),
    .p1_we          (p1_we),
    .p1_addr        (p1_addr),
    .p1_wdata       (p1_wdata),
    .p1_ack         (p1_ack),
    .p1_rdata       (p1_rdata),
    .mem_address    (mem_address),
    .mem_data_write (mem_data_write),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_data_read  (mem_data_read),
    .busy           (busy),
    .gnt_id         (gnt_id)
  );

  // Memory model: combinational read (zero when not reading), write at the clock edge.
  assign mem_data_read = mem_read ? mem[mem_address[8:1]] : 16'h0000;
  always @(posedge clk) if (mem_write) mem[mem_address[8:1]] <= mem_data_write;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (p0_ack || p1_ack)) begin
      check("both_acks", {31'd0, p0_ack & p1_ack}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", {31'd0, p1_ack}, {31'd0, e.port});
        check("ack_gnt_id", {31'd0, gnt_id}, {31'd0, e.port});
        check("ack_rdata", {16'd0, (p1_ack ? p1_rdata : p0_rdata)}, {16'd0, e.rdata});
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_acks"}, {30'd0, p1_ack, p0_ack}, 32'd0);
    check({tag, "_rdata"}, {p1_rdata, p0_rdata}, 32'd0);
    check({tag, "_mem_addr"}, {16'd0, mem_address}, 32'd0);
    check({tag, "_mem_wdata"}, {16'd0, mem_data_write}, 32'd0);
    check({tag, "_mem_strobes"}, {30'd0, mem_write, mem_read}, 32'd0);
    check({tag, "_busy_gnt"}, {30'd0, busy, gnt_id}, 32'd0);
  endtask

  task automatic do_txn(input vec_t v);
    int  n;
    bit  seen;
    exp_t e;
    @(negedge clk);
    if (v.port) begin
      p1_req = 1'b1; p1_we = v.we; p1_addr = v.addr; p1_wdata = v.wdata;
    end else begin
      p0_req = 1'b1; p0_we = v.we; p0_addr = v.addr; p0_wdata = v.wdata;
    end
    e.port = v.port;
    e.rdata = v.exp_rdata;
    sb.push_back(e);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("acc_strobes", {30'd0, mem_write, mem_read}, {30'd0, v.we, !v.we});
        check("acc_addr", {16'd0, mem_address}, {16'd0, v.addr});
        check("acc_busy", {31'd0, busy}, 32'd1);
        if (v.we) check("acc_wdata", {16'd0, mem_data_write}, {16'd0, v.wdata});
      end
      if (v.port ? p1_ack : p0_ack) seen = 1'b1;
    end
    check("txn_latency", n, 32'd2);
    if (v.port) p1_req = 1'b0; else p0_req = 1'b0;
  endtask

  initial begin
    int  cyc, c0, c1, acks;
    bit  g0, g1;
    exp_t e;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h2020;  // 0x0020
    mem[8'h18] = 16'h3030;  // 0x0030
    mem[8'h20] = 16'h4040;  // 0x0040
    mem[8'h28] = 16'h5050;  // 0x0050
    mem[8'h38] = 16'h00AA;  // 0x0070

    vecs.push_back('{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h3030});
    vecs.push_back('{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF});
    vecs.push_back('{1'b0, 1'b0, 16'h0070, 16'h0000, 16'h00AA});
    vecs.push_back('{1'b0, 1'b1, 16'h0070, 16'h5555, 16'h00AA});
    vecs.push_back('{1'b1, 1'b0, 16'h0070, 16'h0000, 16'h5555});
    vecs.push_back('{1'b0, 1'b1, 16'h0011, 16'h0101, 16'h5555});
    vecs.push_back('{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0101});

    rst_n = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Tie from reset: p0 first, p1 three cycles later.
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 16'h0020;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0030;
    e.port = 1'b0; e.rdata = 16'h2020; sb.push_back(e);
    e.port = 1'b1; e.rdata = 16'h3030; sb.push_back(e);
    cyc = 0; c0 = -1; c1 = -1; g0 = 1'b1; g1 = 1'b0;
    while (c1 < 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (p0_ack) begin c0 = cyc; g0 = gnt_id; p0_req = 0; end
      if (p1_ack) begin c1 = cyc; g1 = gnt_id; p1_req = 0; end
    end
    check("tie_p0_latency", c0, 32'd2);
    check("tie_p1_after_p0", c1 - c0, 32'd3);
    check("tie_gnt_seq", {30'd0, g0, g1}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) do_txn(vecs[i]);

    // Both ports hold requests for six transactions; expect strict alternation.
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 16'h0020;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0030;
    for (int i = 0; i < 6; i++) begin
      e.port = i[0];
      e.rdata = i[0] ? 16'h3030 : 16'h2020;
      sb.push_back(e);
    end
    acks = 0; cyc = 0;
    while (acks < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (p0_ack || p1_ack) acks++;
      if (acks == 6) begin p0_req = 0; p1_req = 0; end
    end
    check("rr_ack_count", acks, 32'd6);
    check("rr_cycles", cyc, 32'd17);
    repeat (4) @(negedge clk);

    // Address changed during ACCESS: the latched address is used.
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 16'h0040;
    e.port = 1'b0; e.rdata = 16'h4040; sb.push_back(e);
    @(negedge clk);
    p0_addr = 16'h0050;
    check("chg_mem_addr", {16'd0, mem_address}, 32'h0040);
    cyc = 0; g0 = 1'b0;
    while (!g0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (p0_ack) g0 = 1'b1;
    end
    check("chg_ack_fired", {31'd0, g0}, 32'd1);
    p0_req = 0;

    // Reset during the ACCESS of a write: no write, ack lost.
    @(negedge clk);
    p0_req = 1; p0_we = 1; p0_addr = 16'h0060; p0_wdata = 16'h1234;
    @(negedge clk);
    check("rst_acc_write_seen", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_write_drop", {31'd0, mem_write}, 32'd0);
    check_idle_outputs("rst_mid");
    p0_req = 0;
    repeat (2) @(negedge clk);
    check_idle_outputs("rst_hold");
    rst_n = 1'b1;
    do_txn('{1'b0, 1'b0, 16'h0060, 16'h0000, 16'h0000});

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
